// File: rtl/pwm_pkg.sv
// Shared mode constants and FSM state encoding for the PWM pattern scheduler.
package pwm_pkg;

    localparam logic [1:0] MODE_OFF     = 2'd0;
    localparam logic [1:0] MODE_SQUARE  = 2'd1;
    localparam logic [1:0] MODE_RAMP    = 2'd2;
    localparam logic [1:0] MODE_BREATHE = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PENDING = 2'd2
    } state_t;

endpackage

// File: rtl/pwm_duty_calc.sv
// Combinational duty lookup: maps the active pattern mode and a channel's frame index to a duty value.
module pwm_duty_calc
    import pwm_pkg::*;
#(
    parameter int CNT_W = 6,
    parameter int IDX_W = 6
) (
    input  logic [1:0]       i_mode,
    input  logic [IDX_W-1:0] i_idx,
    output logic [CNT_W:0]   o_duty
);

    localparam logic [CNT_W:0] FULL = {1'b1, {CNT_W{1'b0}}};

    logic [IDX_W-2:0] w_tri;

    always_comb begin
        // Triangle fold: rising over the first half-cycle, mirrored over the second.
        w_tri  = i_idx[IDX_W-1] ? ~i_idx[IDX_W-2:0] : i_idx[IDX_W-2:0];
        o_duty = '0;
        case (i_mode)
            MODE_SQUARE:  o_duty = i_idx[IDX_W-1] ? '0 : FULL;
            MODE_RAMP:    o_duty = (CNT_W+1)'(i_idx) << (CNT_W - IDX_W);
            MODE_BREATHE: o_duty = (CNT_W+1)'(w_tri) << (CNT_W - IDX_W + 1);
            default:      o_duty = '0;
        endcase
    end

endmodule

// File: rtl/pwm_pattern_scheduler.sv
// Multi-channel LED PWM pattern scheduler: shared period/frame counters, phase-offset channels,
// and mode changes deferred to period boundaries so no channel sees a truncated period.
module pwm_pattern_scheduler
    import pwm_pkg::*;
#(
    parameter int CNT_W      = 6,
    parameter int IDX_W      = 6,
    parameter int NUM_CH     = 3,
    parameter int PHASE_STEP = 21
) (
    input  logic              sysclk,
    input  logic              rst,
    input  logic              enable_sw,
    input  logic [1:0]        mode_sel,
    input  logic              mode_load,
    output logic [NUM_CH-1:0] pulse,
    output logic [1:0]        active_mode,
    output logic              mode_ack,
    output logic              frame_tick
);

    logic             r_sync1;
    logic             r_en_s;
    state_t           r_state;
    logic [CNT_W-1:0] r_count;
    logic [IDX_W-1:0] r_idx;
    logic [1:0]       r_shadow;

    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_count_nxt;
    logic [IDX_W-1:0] w_idx_nxt;
    logic [1:0]       w_shadow_nxt;
    logic [1:0]       w_mode_nxt;
    logic             w_ack_nxt;
    logic             w_tick_nxt;
    logic             w_period_end;
    logic [NUM_CH-1:0] w_on;

    assign w_period_end = (r_state != ST_IDLE) && (r_count == '1);

    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            r_sync1     <= 1'b0;
            r_en_s      <= 1'b0;
            r_state     <= ST_IDLE;
            r_count     <= '0;
            r_idx       <= '0;
            r_shadow    <= MODE_OFF;
            active_mode <= MODE_OFF;
            mode_ack    <= 1'b0;
            frame_tick  <= 1'b0;
            pulse       <= '0;
        end else begin
            r_sync1     <= enable_sw;
            r_en_s      <= r_sync1;
            r_state     <= w_state_nxt;
            r_count     <= w_count_nxt;
            r_idx       <= w_idx_nxt;
            r_shadow    <= w_shadow_nxt;
            active_mode <= w_mode_nxt;
            mode_ack    <= w_ack_nxt;
            frame_tick  <= w_tick_nxt;
            pulse       <= w_on;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_count_nxt  = r_count;
        w_idx_nxt    = r_idx;
        w_shadow_nxt = r_shadow;
        w_mode_nxt   = active_mode;
        w_ack_nxt    = 1'b0;
        w_tick_nxt   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_count_nxt = '0;
                w_idx_nxt   = '0;
                if (mode_load) begin
                    w_mode_nxt = mode_sel;
                    w_ack_nxt  = 1'b1;
                end
                if (r_en_s && (active_mode != MODE_OFF)) w_state_nxt = ST_RUN;
            end
            ST_RUN, ST_PENDING: begin
                w_count_nxt = r_count + 1'b1;
                if (w_period_end) begin
                    w_idx_nxt  = r_idx + 1'b1;
                    w_tick_nxt = (r_idx == '1);
                end
                // Last request wins, including one arriving on the boundary cycle itself.
                if (mode_load) begin
                    w_shadow_nxt = mode_sel;
                    w_state_nxt  = ST_PENDING;
                end
                if ((r_state == ST_PENDING) && w_period_end) begin
                    w_mode_nxt  = w_shadow_nxt;
                    w_ack_nxt   = 1'b1;
                    w_idx_nxt   = '0;
                    w_state_nxt = (w_shadow_nxt == MODE_OFF) ? ST_IDLE : ST_RUN;
                end
                if (!r_en_s) begin
                    w_state_nxt = ST_IDLE;
                    w_count_nxt = '0;
                    w_idx_nxt   = '0;
                    w_tick_nxt  = 1'b0;
                    if (r_state == ST_PENDING) begin
                        w_mode_nxt = w_shadow_nxt;
                        w_ack_nxt  = 1'b1;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        logic [IDX_W-1:0] w_idx_ch;
        logic [CNT_W:0]   w_duty;

        // Truncation to IDX_W bits gives the modulo-2**IDX_W phase wrap.
        assign w_idx_ch = r_idx + IDX_W'(ch * PHASE_STEP);

        pwm_duty_calc #(
            .CNT_W (CNT_W),
            .IDX_W (IDX_W)
        ) u_duty (
            .i_mode (active_mode),
            .i_idx  (w_idx_ch),
            .o_duty (w_duty)
        );

        assign w_on[ch] = (r_state != ST_IDLE) && r_en_s && ({1'b0, r_count} < w_duty);
    end

endmodule

// File: tb/tb_pwm_pattern_scheduler.sv
// Directed self-checking bench for pwm_pattern_scheduler at default parameters.
module tb_pwm_pattern_scheduler;
    import pwm_pkg::*;

    logic       sysclk;
    logic       rst;
    logic       enable_sw;
    logic [1:0] mode_sel;
    logic       mode_load;
    logic [2:0] pulse;
    logic [1:0] active_mode;
    logic       mode_ack;
    logic       frame_tick;

    int n_cmp = 0;
    int n_err = 0;

    pwm_pattern_scheduler #(
        .CNT_W      (6),
        .IDX_W      (6),
        .NUM_CH     (3),
        .PHASE_STEP (21)
    ) dut (
        .sysclk      (sysclk),
        .rst         (rst),
        .enable_sw   (enable_sw),
        .mode_sel    (mode_sel),
        .mode_load   (mode_load),
        .pulse       (pulse),
        .active_mode (active_mode),
        .mode_ack    (mode_ack),
        .frame_tick  (frame_tick)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [1:0] m);
        mode_sel  = m;
        mode_load = 1'b1;
        @(posedge sysclk);
        #1;
        mode_load = 1'b0;
    endtask

    task automatic wait_cnt(input string tag, input int n);
        bit found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge sysclk);
            if (dut.r_state != ST_IDLE && int'(dut.r_count) == n) found = 1;
        end
        chk({tag, "_reached"}, int'(found), 1);
    endtask

    task automatic measure(input string tag, input int frame, output int h0, output int h1, output int h2);
        bit found = 0;
        h0 = 0; h1 = 0; h2 = 0;
        for (int i = 0; i < 6000 && !found; i++) begin
            @(negedge sysclk);
            if (dut.r_state != ST_IDLE && int'(dut.r_idx) == frame && dut.r_count == 0) found = 1;
        end
        chk({tag, "_reached"}, int'(found), 1);
        if (found) begin
            for (int k = 0; k < 64; k++) begin
                @(posedge sysclk);
                @(negedge sysclk);
                h0 += int'(pulse[0]);
                h1 += int'(pulse[1]);
                h2 += int'(pulse[2]);
            end
        end
    endtask

    task automatic wait_tick(output int cyc);
        bit found = 0;
        cyc = 0;
        for (int i = 0; i < 5000 && !found; i++) begin
            @(posedge sysclk);
            #1;
            cyc++;
            if (frame_tick) found = 1;
        end
        chk("frame_tick_seen", int'(found), 1);
    endtask

    initial begin
        int h0, h1, h2, cyc, acks, am, ix, cn;
        bit got;
        rst = 1'b1; enable_sw = 1'b0; mode_sel = MODE_OFF; mode_load = 1'b0;
        repeat (3) @(posedge sysclk);
        #1;
        chk("rst_pulse", int'(pulse), 0);
        chk("rst_mode", int'(active_mode), 0);
        chk("rst_ack", int'(mode_ack), 0);
        chk("rst_tick", int'(frame_tick), 0);
        @(negedge sysclk);
        rst = 1'b0;

        // SQUARE loaded from IDLE, acknowledged on the next cycle
        enable_sw = 1'b1;
        repeat (3) @(posedge sysclk);
        #1;
        load(MODE_SQUARE);
        chk("idle_load_ack", int'(mode_ack), 1);
        chk("idle_load_mode", int'(active_mode), 1);
        @(posedge sysclk);
        #1;
        chk("idle_ack_single", int'(mode_ack), 0);
        measure("sq_f0", 0, h0, h1, h2);
        chk("sq_f0_ch0", h0, 64);
        measure("sq_f31", 31, h0, h1, h2);
        chk("sq_f31_ch0", h0, 64);
        measure("sq_f32", 32, h0, h1, h2);
        chk("sq_f32_ch0", h0, 0);
        measure("sq_f63", 63, h0, h1, h2);
        chk("sq_f63_ch0", h0, 0);
        wait_tick(cyc);
        wait_tick(cyc);
        chk("frame_tick_period", cyc, 4096);
        @(posedge sysclk);
        #1;
        chk("frame_tick_width", int'(frame_tick), 0);

        // Two deferred requests in one period collapse into a single ack
        wait_cnt("cnt20", 20);
        load(MODE_RAMP);
        wait_cnt("cnt30", 30);
        load(MODE_BREATHE);
        chk("pend_no_early_ack", int'(mode_ack), 0);
        chk("pend_mode_held", int'(active_mode), 1);
        acks = 0; am = -1; ix = -1; cn = -1;
        for (int i = 0; i < 64; i++) begin
            @(posedge sysclk);
            #1;
            if (mode_ack) begin
                acks++;
                am = int'(active_mode);
                ix = int'(dut.r_idx);
                cn = int'(dut.r_count);
            end
        end
        chk("pend_ack_count", acks, 1);
        chk("pend_ack_mode", am, 3);
        chk("pend_ack_idx", ix, 0);
        chk("pend_ack_count_wrap", cn, 0);

        // BREATHE shape
        measure("br_f31", 31, h0, h1, h2);
        chk("br_f31_ch0", h0, 62);
        chk("br_f31_ch1", h1, 22);
        measure("br_f40", 40, h0, h1, h2);
        chk("br_f40_ch0", h0, 46);
        measure("br_f63", 63, h0, h1, h2);
        chk("br_f63_ch0", h0, 0);

        // RAMP, switched at the next boundary
        load(MODE_RAMP);
        got = 0;
        for (int i = 0; i < 100 && !got; i++) begin
            if (mode_ack) got = 1;
            else begin
                @(posedge sysclk);
                #1;
            end
        end
        chk("ramp_ack_seen", int'(got), 1);
        chk("ramp_mode", int'(active_mode), 2);
        chk("ramp_idx0", int'(dut.r_idx), 0);
        measure("rp_f0", 0, h0, h1, h2);
        chk("rp_f0_ch0", h0, 0);
        chk("rp_f0_ch1", h1, 21);
        chk("rp_f0_ch2", h2, 42);
        measure("rp_f10", 10, h0, h1, h2);
        chk("rp_f10_ch0", h0, 10);

        // Disable: outputs drop within the synchroniser latency plus one
        enable_sw = 1'b0;
        repeat (3) @(posedge sysclk);
        #1;
        chk("dis_pulse", int'(pulse), 0);
        chk("dis_count", int'(dut.r_count), 0);
        chk("dis_idx", int'(dut.r_idx), 0);
        repeat (5) @(posedge sysclk);
        #1;
        chk("dis_hold_pulse", int'(pulse), 0);
        enable_sw = 1'b1;
        measure("re_f0", 0, h0, h1, h2);
        chk("re_mode", int'(active_mode), 2);
        chk("re_f0_ch1", h1, 21);
        chk("re_f0_ch2", h2, 42);

        // Asynchronous reset mid-period, observed before any clock edge
        wait_cnt("cnt17", 17);
        chk("pre_rst_pulse", int'(pulse), 6);
        rst = 1'b1;
        #1;
        chk("async_rst_pulse", int'(pulse), 0);
        chk("async_rst_mode", int'(active_mode), 0);
        chk("async_rst_ack", int'(mode_ack), 0);
        chk("async_rst_count", int'(dut.r_count), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
